bbs_checker: RTL and testbench

Stream checker for the Blum Blum Shub generator output. It accepts successive generator samples over a valid/ready handshake and recomputes the expected next value x(n+1) = x(n)² mod M with a bit-serial modular squarer. It reports mismatches, counts good samples and measures the cycle length of the sequence. It sits downstream of the generator, as the consumer end of its output stream, in both silicon test and simulation.

---
 rtl/bbs_checker.sv | 173 +++++++++++++++++
 tb/tb_bbs_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bbs_checker.sv
// bbs_checker: consumer-side checker for a Blum Blum Shub sample stream.
// Recomputes x(n+1) = x(n)^2 mod M with an MSB-first bit-serial modular
// squarer, flags mismatches, counts good samples and measures the period.
module bbs_checker #(
    parameter int unsigned W  = 16,
    parameter logic [W-1:0] M = W'(253),
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          err_pulse,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] match_count,
    output logic          period_valid,
    output logic [CW-1:0] period
);

    localparam int unsigned DW = W + 1;
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [DW-1:0] M_X = DW'(M);

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        CALC  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  expected_q, expected_d;
    logic [W-1:0]  ref_val_q, ref_val_d;
    logic [W-1:0]  seed_q, seed_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [IW-1:0] bit_q, bit_d;

    logic          in_ready_d;
    logic          err_pulse_d;
    logic [CW-1:0] err_count_d;
    logic [CW-1:0] match_count_d;
    logic          period_valid_d;
    logic [CW-1:0] period_d;

    logic          xfer;
    logic [DW-1:0] step_dbl;
    logic [DW-1:0] step_sum;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign xfer = in_valid && in_ready;

    // One interleaved modular-multiply step: acc = (2*acc + ref[i]*ref) mod M.
    always_comb begin
        step_dbl = {acc_q, 1'b0};
        if (step_dbl >= M_X) begin
            step_dbl = step_dbl - M_X;
        end
        step_sum = step_dbl;
        if (ref_val_q[bit_q]) begin
            step_sum = step_dbl + {1'b0, ref_val_q};
        end
        if (step_sum >= M_X) begin
            step_sum = step_sum - M_X;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        expected_d     = expected_q;
        ref_val_d      = ref_val_q;
        seed_d         = seed_q;
        pcnt_d         = pcnt_q;
        bit_d          = bit_q;
        err_pulse_d    = 1'b0;
        err_count_d    = err_count;
        match_count_d  = match_count;
        period_valid_d = period_valid;
        period_d       = period;

        case (state_q)
            SEED: begin
                if (xfer) begin
                    if (in_data < M) begin
                        seed_d    = in_data;
                        ref_val_d = in_data;
                        pcnt_d    = '0;
                        acc_d     = '0;
                        bit_d     = IW'(W - 1);
                        state_d   = CALC;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count);
                    end
                end
            end
            CALC: begin
                acc_d = step_sum[W-1:0];
                if (bit_q == '0) begin
                    expected_d = step_sum[W-1:0];
                    state_d    = ARMED;
                end else begin
                    bit_d = bit_q - IW'(1);
                end
            end
            ARMED: begin
                if (xfer) begin
                    pcnt_d = sat_inc(pcnt_q);
                    if (in_data == expected_q) begin
                        match_count_d = sat_inc(match_count);
                        ref_val_d     = in_data;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count);
                        // Resync on an in-range sample, otherwise keep the model.
                        ref_val_d   = (in_data < M) ? in_data : expected_q;
                    end
                    if (!period_valid && (in_data == seed_q)) begin
                        period_d       = sat_inc(pcnt_q);
                        period_valid_d = 1'b1;
                    end
                    acc_d   = '0;
                    bit_d   = IW'(W - 1);
                    state_d = CALC;
                end
            end
            default: begin
                state_d = SEED;
            end
        endcase

        in_ready_d = (state_d != CALC);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEED;
            acc_q        <= '0;
            expected_q   <= '0;
            ref_val_q    <= '0;
            seed_q       <= '0;
            pcnt_q       <= '0;
            bit_q        <= '0;
            in_ready     <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            match_count  <= '0;
            period_valid <= 1'b0;
            period       <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            expected_q   <= expected_d;
            ref_val_q    <= ref_val_d;
            seed_q       <= seed_d;
            pcnt_q       <= pcnt_d;
            bit_q        <= bit_d;
            in_ready     <= in_ready_d;
            err_pulse    <= err_pulse_d;
            err_count    <= err_count_d;
            match_count  <= match_count_d;
            period_valid <= period_valid_d;
            period       <= period_d;
        end
    end

endmodule

// File: tb/tb_bbs_checker.sv
// Directed, table-driven bench for bbs_checker. Three instances:
// unit 0: W=16 M=253 CW=16, unit 1: W=8 M=21 CW=16,
// unit 2: W=8 M=21 CW=3 (small counters to reach saturation quickly).
module tb_bbs_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    int          sel;

    int errors;
    int checks;

    // Unit 0 signals
    logic        r0, ep0, pv0;
    logic [15:0] ec0, mc0, pr0;
    // Unit 1 signals
    logic        r1, ep1, pv1;
    logic [15:0] ec1, mc1, pr1;
    // Unit 2 signals
    logic        r2, ep2, pv2;
    logic [2:0]  ec2, mc2, pr2;

    logic v0, v1, v2;
    assign v0 = in_valid && (sel == 0);
    assign v1 = in_valid && (sel == 1);
    assign v2 = in_valid && (sel == 2);

    bbs_checker #(.W(16), .M(16'd253), .CW(16)) u0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(in_data),
        .in_ready(r0), .err_pulse(ep0), .err_count(ec0), .match_count(mc0),
        .period_valid(pv0), .period(pr0)
    );

    bbs_checker #(.W(8), .M(8'd21), .CW(16)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_data(in_data[7:0]),
        .in_ready(r1), .err_pulse(ep1), .err_count(ec1), .match_count(mc1),
        .period_valid(pv1), .period(pr1)
    );

    bbs_checker #(.W(8), .M(8'd21), .CW(3)) u2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(in_data[7:0]),
        .in_ready(r2), .err_pulse(ep2), .err_count(ec2), .match_count(mc2),
        .period_valid(pv2), .period(pr2)
    );

    // Selected unit's outputs
    logic        o_ready, o_ep, o_pv;
    logic [15:0] o_ec, o_mc, o_pr;

    always_comb begin
        o_ready = r0; o_ep = ep0; o_pv = pv0;
        o_ec = ec0; o_mc = mc0; o_pr = pr0;
        case (sel)
            1: begin
                o_ready = r1; o_ep = ep1; o_pv = pv1;
                o_ec = ec1; o_mc = mc1; o_pr = pr1;
            end
            2: begin
                o_ready = r2; o_ep = ep2; o_pv = pv2;
                o_ec = {13'd0, ec2}; o_mc = {13'd0, mc2}; o_pr = {13'd0, pr2};
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst;   // apply reset before this vector
        int unit;
        int data;
        int ep;
        int ec;
        int mc;
        int pv;
        int per;
        int low;   // cycles in_ready stays low after the transfer
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int rst, input int unit, input int data,
                                input int ep, input int ec, input int mc,
                                input int pv, input int per, input int low);
        vec_t v;
        v.rst = rst; v.unit = unit; v.data = data; v.ep = ep; v.ec = ec;
        v.mc = mc; v.pv = pv; v.per = per; v.low = low;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".in_ready"},     int'(o_ready), 0);
        chk({tag, ".err_pulse"},    int'(o_ep), 0);
        chk({tag, ".err_count"},    int'(o_ec), 0);
        chk({tag, ".match_count"},  int'(o_mc), 0);
        chk({tag, ".period_valid"}, int'(o_pv), 0);
        chk({tag, ".period"},       int'(o_pr), 0);
    endtask

    // Wait for in_ready, present data, return #1 after the transfer edge.
    task automatic send(input int d);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!o_ready && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        chk("send_ready_timeout", int'(o_ready), 1);
        in_valid = 1'b1;
        in_data  = 16'(d);
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid high while busy; count cycles until in_ready returns.
    task automatic drain(output int low);
        low = 0;
        forever begin
            @(negedge clk);
            if (o_ready || low >= 200) break;
            low++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int low;
        errors   = 0;
        checks   = 0;
        sel      = 0;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;

        // Nominal M=253 sequence: 3, 9, 81, 236, 36
        add(1, 0,   3, 0, 0, 0, 0, 0, 16);
        add(0, 0,   9, 0, 0, 1, 0, 0, 16);
        add(0, 0,  81, 0, 0, 2, 0, 0, 16);
        add(0, 0, 236, 0, 0, 3, 0, 0, 16);
        add(0, 0,  36, 0, 0, 4, 0, 0, 16);
        // Corrupted sample 100 in place of 236, resync makes 133 match
        add(1, 0,   3, 0, 0, 0, 0, 0, 16);
        add(0, 0,   9, 0, 0, 1, 0, 0, 16);
        add(0, 0,  81, 0, 0, 2, 0, 0, 16);
        add(0, 0, 100, 1, 1, 2, 0, 0, 16);
        add(0, 0, 133, 0, 1, 3, 0, 0, 16);
        // Out-of-range seed rejected, then out-of-range sample in ARMED keeps model
        add(1, 0, 300, 1, 1, 0, 0, 0, 0);
        add(0, 0,   3, 0, 1, 0, 0, 0, 16);
        add(0, 0,   9, 0, 1, 1, 0, 0, 16);
        add(0, 0, 300, 1, 2, 1, 0, 0, 16);
        add(0, 0, 236, 0, 2, 2, 0, 0, 16);
        // M=21 W=8: 4 -> 16 -> 4, period 2, not updated later
        add(1, 1,   4, 0, 0, 0, 0, 0, 8);
        add(0, 1,  16, 0, 0, 1, 0, 0, 8);
        add(0, 1,   4, 0, 0, 2, 1, 2, 8);
        add(0, 1,  16, 0, 0, 3, 1, 2, 8);
        add(0, 1,   4, 0, 0, 4, 1, 2, 8);
        // Zero fixed point with 3-bit counters: match_count saturates at 7
        add(1, 2, 0, 0, 0, 0, 0, 0, 8);
        for (int i = 1; i <= 9; i++) begin
            add(0, 2, 0, 0, 0, (i < 7) ? i : 7, 1, 1, 8);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (vecs[i].rst != 0) begin
                sel = vecs[i].unit;
                do_reset();
                chk_reset_vals({tag, ".rst"});
            end
            send(vecs[i].data);
            chk({tag, ".err_pulse"},    int'(o_ep), vecs[i].ep);
            chk({tag, ".err_count"},    int'(o_ec), vecs[i].ec);
            chk({tag, ".match_count"},  int'(o_mc), vecs[i].mc);
            chk({tag, ".period_valid"}, int'(o_pv), vecs[i].pv);
            chk({tag, ".period"},       int'(o_pr), vecs[i].per);
            drain(low);
            chk({tag, ".ready_low"},    low, vecs[i].low);
        end

        // Reset five cycles into CALC aborts everything
        sel = 0;
        do_reset();
        send(3);
        drain(low);
        send(9);
        chk("mid.pre_match", int'(o_mc), 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd3;
        repeat (4) @(negedge clk);
        chk("mid.in_calc", int'(o_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("mid.rst");
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.ready_after", int'(o_ready), 1);
        send(3);
        chk("mid.reseed_mc", int'(o_mc), 0);
        chk("mid.reseed_ec", int'(o_ec), 0);
        drain(low);
        send(9);
        chk("mid.after_mc", int'(o_mc), 1);
        drain(low);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
